rr_decode_arbiter: RTL and testbench
====================================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 decoded select resource among 8 requesters.
- Latches a winner index, drives the one-hot grant through the team's 3-to-8 decoder, and holds the grant until the owner releases it.
- Sits between requesting agents and the shared decoded select lines.
- Guarantees fairness: each requester waits at most 7 other tenures.

Parameters:
- N, 8, number of requesters (fixed at 8 for the 3-to-8 decoder).
- IDXW, 3, width of the grant index.
- HOLD_MAX, 16, maximum cycles a grant may be held (used only when the timeout feature is compiled in).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request vector; bit i high means requester i wants the resource.
- done  in  1  release pulse from the current owner; sampled only while granted.
- grant  out  8  one-hot grant; decoder output of grant_idx, gated by grant_valid.
- grant_idx  out  3  registered index of the current owner.
- grant_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, immediate): state=IDLE, grant_valid=0, grant=8'h00, grant_idx=0, ptr=0, hold_cnt=0, timeout=0.
- An asserted reset mid-grant drops grant on the same cycle, without waiting for a clock edge.
- State IDLE:
  - On an edge with req!=0, select the first set bit searching ptr, ptr+1, ..., wrapping mod 8.
  - At that edge: grant_idx<=winner, grant_valid<=1, hold_cnt<=0, go to GRANT.
  - Latency: req is sampled at edge k; grant is visible after edge k.
  - With req==0, remain in IDLE; outputs stay 0.
- State GRANT:
  - Release when done==1 OR req[grant_idx]==0 at an edge.
  - On release: grant_valid<=0, ptr<=(grant_idx+1) mod 8 (7 wraps to 0), go to IDLE.
  - Otherwise hold; hold_cnt increments and saturates at HOLD_MAX.
- Dead cycle: exactly one IDLE cycle with grant=0 between consecutive tenures (bus turnaround). Back-to-back grants are therefore spaced by at least one idle cycle.
- Owner re-requesting: if the owner keeps req high through its release, it goes to the back of the rotation. It can win again only if no other requester is set.
- Signal rules:
  - done asserted in IDLE is ignored.
  - Changes to req bits other than grant_idx during GRANT have no effect.
  - grant is always one-hot or zero, never multi-hot.
- Arithmetic:
  - ptr and grant_idx are 3-bit and wrap naturally.
  - hold_cnt width is $clog2(HOLD_MAX+1).

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt reaches HOLD_MAX-1 and no release occurs, the next edge forces a release.
  - That release follows the normal path (ptr advances, go to IDLE) and asserts timeout=1 for that one cycle.
  - A grant therefore lasts at most HOLD_MAX cycles.
- Undefined:
  - No forced release; a grant lasts until done or request withdrawal.
  - timeout is tied to 0 and hold_cnt logic is removed.

Decomposition:
- Package rr_arb_pkg holds:
  - localparams N=8, IDXW=3.
  - State enum typedef {IDLE, GRANT}.
  - Function next_winner(req, ptr) returning the 3-bit index for the rotating priority search.
- Sub-module: the existing decoder (3-bit in, 8-bit one-hot out), instantiated once on grant_idx. The top ANDs its output with {8{grant_valid}}.
- Arbitration, FSM and counter stay in rr_decode_arbiter.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> grant=8'h00, grant_valid=0, timeout=0 throughout.
- Async reset mid-grant: req=8'h08, grant=8'h08 held, rst pulsed between edges -> grant=8'h00 immediately, grant_idx=0.
- Single requester: req=8'h04 at edge 1 -> grant=8'h04, grant_idx=2 after edge 1; done pulse at edge 4 -> grant=0 after edge 4; req still high -> regrant 8'h04 after edge 5.
- Rotation and wrap: req=8'hFF held, done pulsed every 3rd cycle -> grant_idx sequence 0,1,2,...,7,0; each tenure is separated by one grant=0 cycle.
- Fairness: req=8'h81 held, owner 7 releasing -> ptr wraps to 0, next grant=8'h01. Then releasing 0 -> grant=8'h80.
- Withdrawal and timeout: req=8'h10 granted, then req[4] dropped -> release on that edge, ptr=5. With RR_ARB_TIMEOUT_EN, HOLD_MAX=16, req=8'h10 held and no done -> forced release after 16 grant cycles, timeout=1 for exactly one cycle.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin decode arbiter: sizes, FSM states
// and the rotating-priority search used to pick the next winner.
package rr_arb_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Returns the first set request found when searching ptr, ptr+1, ...
    // wrapping modulo N. The result is only meaningful when req is non-zero.
    function automatic logic [IDXW-1:0] next_winner(input logic [N-1:0]    req,
                                                    input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] idx;
        logic [IDXW-1:0] win;
        logic            found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + IDXW'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_decoder.sv
// 3-to-8 one-hot decoder driving the shared select lines.
import rr_arb_pkg::*;

module rr_decode_arbiter_decoder (
    input  logic [IDXW-1:0] sel,
    output logic [N-1:0]    onehot
);

    // Exactly one output bit follows the binary select value.
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one decoded select resource among 8 requesters.
// A winner is latched and held until it pulses done or drops its request;
// one idle cycle always separates consecutive tenures.
// Optional macro RR_ARB_TIMEOUT_EN adds a forced release after HOLD_MAX
// grant cycles, signalled by a one-cycle timeout pulse.
import rr_arb_pkg::*;

module rr_decode_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid,
    output logic            timeout
);

    arb_state_t      state;
    arb_state_t      state_next;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] winner;
    logic [N-1:0]    dec_out;
    logic            release_normal;
    logic            release_forced;
    logic            release_any;

    assign winner         = next_winner(req, ptr);
    assign release_normal = (state == GRANT) && (done || !req[grant_idx]);
    assign release_any    = release_normal || release_forced;

    // State register; reset drops any held grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: claim on any request, return to IDLE on release.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req != '0) state_next = GRANT;
            GRANT:   if (release_any) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner on claim and move the priority pointer past the owner on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_idx <= '0;
            ptr       <= '0;
        end else if (state == IDLE && req != '0) begin
            grant_idx <= winner;
        end else if (state == GRANT && release_any) begin
            ptr <= grant_idx + IDXW'(1);
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNTW = $clog2(HOLD_MAX + 1);

    logic [CNTW-1:0] hold_cnt;
    logic            timeout_q;

    assign release_forced = (state == GRANT) && (hold_cnt == CNTW'(HOLD_MAX - 1)) && !release_normal;
    assign timeout        = timeout_q;

    // Count cycles of the current tenure, saturating at HOLD_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
        end else if (hold_cnt != CNTW'(HOLD_MAX)) begin
            hold_cnt <= hold_cnt + CNTW'(1);
        end
    end

    // Pulse timeout during the dead cycle that follows a forced release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= release_forced;
        end
    end
`else
    logic unused_hold_max;

    assign release_forced  = 1'b0;
    assign timeout         = 1'b0;
    assign unused_hold_max = (HOLD_MAX > 0);
`endif

    rr_decode_arbiter_decoder u_decoder (
        .sel    (grant_idx),
        .onehot (dec_out)
    );

    // Outputs: grant lines are the decoded owner, forced to zero outside a tenure.
    always_comb begin
        grant_valid = (state == GRANT);
        grant       = dec_out & {N{grant_valid}};
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed self-checking bench for rr_decode_arbiter. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_rr_decode_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_decode_arbiter #(.HOLD_MAX(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    // 10 ns clock, rising edge active.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a run that never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkGrant(input string tag, input logic [7:0] g, input logic [2:0] idx, input logic v);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
        checkOutput({tag, ".grant_idx"}, 32'(grant_idx), 32'(idx));
        checkOutput({tag, ".grant_valid"}, 32'(grant_valid), 32'(v));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".grant"}, 32'(grant), 32'h0);
        checkOutput({tag, ".grant_valid"}, 32'(grant_valid), 32'h0);
        checkOutput({tag, ".timeout"}, 32'(timeout), 32'h0);
    endtask

    initial begin
        logic [7:0] expGrant;

        rst = 1'b1;
        applyStimulus(8'h00, 1'b0);
        stepCycle();
        stepCycle();
        checkGrant("reset", 8'h00, 3'd0, 1'b0);
        checkOutput("reset.timeout", 32'(timeout), 32'h0);
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkIdle("idle_noreq");
        end

        // done while idle is ignored.
        applyStimulus(8'h00, 1'b1);
        stepCycle();
        checkIdle("done_in_idle");

        // Single requester 2: grant, hold, done release, regrant.
        applyStimulus(8'h04, 1'b0);
        stepCycle();
        checkGrant("single.grant", 8'h04, 3'd2, 1'b1);
        stepCycle();
        checkGrant("single.hold1", 8'h04, 3'd2, 1'b1);
        stepCycle();
        checkGrant("single.hold2", 8'h04, 3'd2, 1'b1);
        applyStimulus(8'h04, 1'b1);
        stepCycle();
        checkGrant("single.release", 8'h00, 3'd2, 1'b0);
        applyStimulus(8'h04, 1'b0);
        stepCycle();
        checkGrant("single.regrant", 8'h04, 3'd2, 1'b1);
        applyStimulus(8'h00, 1'b0);
        stepCycle();
        checkIdle("single.withdraw");

        // Async reset mid-grant (pointer is 3 here, requester 3 wins).
        applyStimulus(8'h08, 1'b0);
        stepCycle();
        checkGrant("async.grant", 8'h08, 3'd3, 1'b1);
        stepCycle();
        checkGrant("async.hold", 8'h08, 3'd3, 1'b1);
        rst = 1'b1;
        #1;
        checkGrant("async.reset", 8'h00, 3'd0, 1'b0);
        #1;
        rst = 1'b0;
        applyStimulus(8'h00, 1'b0);
        stepCycle();
        checkIdle("async.after");

        // Rotation with all requesting: 0..7 then wrap to 0, dead cycle between.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(8'hFF, 1'b0);
            expGrant = 8'h01 << (k % 8);
            stepCycle();
            checkGrant($sformatf("rot%0d.grant", k), expGrant, 3'(k % 8), 1'b1);
            stepCycle();
            checkGrant($sformatf("rot%0d.hold", k), expGrant, 3'(k % 8), 1'b1);
            applyStimulus(8'hFF, 1'b1);
            stepCycle();
            checkIdle($sformatf("rot%0d.dead", k));
        end
        applyStimulus(8'h00, 1'b0);
        stepCycle();
        checkIdle("rot.end");

        // Fairness across the wrap: pointer is 1, so 7 then 0 then 7.
        applyStimulus(8'h81, 1'b0);
        stepCycle();
        checkGrant("fair.g7", 8'h80, 3'd7, 1'b1);
        applyStimulus(8'h81, 1'b1);
        stepCycle();
        checkIdle("fair.dead1");
        applyStimulus(8'h81, 1'b0);
        stepCycle();
        checkGrant("fair.g0", 8'h01, 3'd0, 1'b1);
        applyStimulus(8'h81, 1'b1);
        stepCycle();
        checkIdle("fair.dead2");
        applyStimulus(8'h81, 1'b0);
        stepCycle();
        checkGrant("fair.g7b", 8'h80, 3'd7, 1'b1);
        applyStimulus(8'h00, 1'b0);
        stepCycle();
        checkIdle("fair.end");

        // Withdrawal: pointer is 0, requester 4 wins; other bits ignored.
        applyStimulus(8'h10, 1'b0);
        stepCycle();
        checkGrant("wd.grant", 8'h10, 3'd4, 1'b1);
        applyStimulus(8'h1F, 1'b0);
        stepCycle();
        checkGrant("wd.others", 8'h10, 3'd4, 1'b1);
        applyStimulus(8'h0F, 1'b0);
        stepCycle();
        checkIdle("wd.release");
        applyStimulus(8'h21, 1'b0);
        stepCycle();
        checkGrant("wd.ptr5", 8'h20, 3'd5, 1'b1);
        applyStimulus(8'h00, 1'b0);
        stepCycle();
        checkIdle("wd.end");

        // Owner re-requesting goes to the back: pointer 6, req 0 and 1.
        applyStimulus(8'h03, 1'b0);
        stepCycle();
        checkGrant("back.g0", 8'h01, 3'd0, 1'b1);
        applyStimulus(8'h03, 1'b1);
        stepCycle();
        checkIdle("back.dead");
        applyStimulus(8'h03, 1'b0);
        stepCycle();
        checkGrant("back.g1", 8'h02, 3'd1, 1'b1);
        applyStimulus(8'h00, 1'b0);
        stepCycle();
        checkIdle("back.end");

`ifdef RR_ARB_TIMEOUT_EN
        // Held request with no done: forced release after 16 grant cycles.
        applyStimulus(8'h10, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            stepCycle();
            checkGrant($sformatf("to.cyc%0d", c), 8'h10, 3'd4, 1'b1);
            checkOutput($sformatf("to.cyc%0d.timeout", c), 32'(timeout), 32'h0);
        end
        stepCycle();
        checkGrant("to.forced", 8'h00, 3'd4, 1'b0);
        checkOutput("to.pulse", 32'(timeout), 32'h1);
        stepCycle();
        checkGrant("to.regrant", 8'h10, 3'd4, 1'b1);
        checkOutput("to.pulse_end", 32'(timeout), 32'h0);
`else
        // Without the timeout feature a held grant persists indefinitely.
        applyStimulus(8'h10, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            stepCycle();
            checkGrant($sformatf("hold.cyc%0d", c), 8'h10, 3'd4, 1'b1);
            checkOutput($sformatf("hold.cyc%0d.timeout", c), 32'(timeout), 32'h0);
        end
`endif
        applyStimulus(8'h00, 1'b0);
        stepCycle();
        checkIdle("final.idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
